runner_sample_producer: RTL and testbench
=========================================

// Module: runner_sample_producer
// PURPOSE
//  Front end feeding the runner step/heart-rate accumulator. Converts raw pedometer and heartbeat
//  pulses into one sample per second: hr_out, steps_per_second, stride_length, plus a 1-cycle valid_out.
//  It drives the accumulator's hr_input/steps_per_second/stride_length/valid_input port group directly.
// PARAMETERS
//  CLK_HZ    1000  clock cycles per 1 s sample window (>=16)
//  HR_WIN    15    heart-rate averaging window in seconds; legal values 15, 30 and 60; HR_MUL = 60/HR_WIN
//  DEBOUNCE  4     cycles after an accepted edge during which further edges on that input are ignored
// PORTS
//  clk              in   1  clock
//  rst              in   1  reset, asynchronous, active-high
//  run              in   1  measurement enable
//  step_raw         in   1  pedometer pulse, asynchronous to clk
//  beat_raw         in   1  heartbeat pulse, asynchronous to clk
//  stride_cfg       in   8  stride length (cm); sampled at window close
//  valid_out        out  1  1-cycle strobe, sample fields valid
//  hr_out           out  8  heart rate, bpm, saturated at 255
//  steps_per_second out  2  steps in closed window, saturated at 3
//  stride_length    out  8  stride_cfg captured at window close
//  hr_warm          out  1  high once HR_WIN windows have closed since reset
// BEHAVIOUR
//  - Reset: all outputs 0. Synchronisers, tick counter, window counts, HR ring buffer, ring sum and fill count are all cleared.
//  - Input path per raw input: 2-FF synchroniser, then rising-edge detect. An edge is accepted
//    only if the debounce counter is 0; acceptance loads the counter with DEBOUNCE-1.
//    Raw-pulse-to-count latency is 3 cycles.
//  - Tick counter counts 0..CLK_HZ-1 while run=1. The window closes on the cycle where tick == CLK_HZ-1.
//    On the next edge: tick <= 0, valid_out <= 1, and all fields are registered.
//  - Window counts: step_cnt is 3 bits, saturating at 7. beat_cnt is 3 bits, saturating at 7.
//    An edge accepted on the close cycle counts in the closing window.
//    Both counts clear at close; an edge on the following cycle counts in the new window.
//  - steps_per_second = min(step_cnt, 3).
//  - HR ring: HR_WIN entries x 3 bits plus a running sum. At close: sum <= sum - oldest + beat_cnt, the oldest entry is overwritten, and the write pointer wraps HR_WIN-1 -> 0.
//  - hr_out = min(new_sum * HR_MUL, 255), computed at full width before saturation. hr_out is reported before warm-up as well.
//  - hr_warm: the fill counter increments at each close and saturates at HR_WIN. hr_warm = (fill == HR_WIN), asserted together with that valid_out.
//  - Outputs other than valid_out hold their values between strobes. valid_out is never asserted on two consecutive cycles.
//  - run=0: tick, window counts and debounce counters clear and hold; no valid_out. The HR ring, fill count and outputs are retained.
//    When run rises, the first valid_out occurs CLK_HZ cycles later.
//  - rst mid-window: immediate clear. The partial window is discarded and no strobe is issued.
// CONFIGURATION
//  RPMS_SAMPLE_OVF_EN defined:
//    - Adds output sample_ovf (1 bit, reset 0), registered at each close.
//    - sample_ovf = (step_cnt > 3) | (beat_cnt == 7) | (hr_out was saturated); it holds between strobes.
//  RPMS_SAMPLE_OVF_EN undefined: the port is absent and saturation is silent. All other behaviour is identical.
// TESTING (CLK_HZ=1000, HR_WIN=15, DEBOUNCE=4)
//  1. Reset:
//     - Release rst with run=1, no pulses -> all outputs 0.
//     - valid_out first asserts exactly 1000 cycles after release, with steps_per_second=0 and hr_out=0.
//  2. Steps:
//     - 2 clean step pulses in one window -> steps_per_second=2.
//     - 5 pulses -> steps_per_second=3, sample_ovf=1 (macro on).
//     - stride_cfg=75 -> stride_length=75.
//  3. Heart rate:
//     - Beat every 500 cycles for 15 windows -> each window has beat_cnt=2.
//     - 15th valid_out: hr_out=120, hr_warm=1 on that strobe.
//     - Earlier strobes: hr_out = 8*k after the k-th window, hr_warm=0.
//  4. Debounce/edge:
//     - Step pulse bouncing with 3 rising edges within 4 cycles -> counts 1.
//     - A step edge on the window-close cycle counts in the closing window.
//  5. Reset mid-window: assert rst at tick 600 -> all outputs 0 immediately; next valid_out 1000 cycles after release.
//  6. run gating:
//     - Drop run for 300 cycles mid-window -> no valid_out; outputs and hr_out are held.
//     - Next valid_out comes 1000 cycles after run rises; pulses during run=0 are not counted.

Source files
------------

// File: rtl/runner_sample_producer_if.sv
// Port group between the sample producer and the runner step/heart-rate accumulator.
// sample_ovf exists only when RPMS_SAMPLE_OVF_EN is defined.
interface runner_sample_producer_if;
  logic       run;
  logic       step_raw;
  logic       beat_raw;
  logic [7:0] stride_cfg;
  // valid_out is a 1-cycle strobe with no ready: the accumulator takes every sample,
  // and the fields stay stable until the next strobe.
  logic       valid_out;
  logic [7:0] hr_out;
  logic [1:0] steps_per_second;
  logic [7:0] stride_length;
  logic       hr_warm;
`ifdef RPMS_SAMPLE_OVF_EN
  logic       sample_ovf;

  modport master (
    input  run, step_raw, beat_raw, stride_cfg,
    output valid_out, hr_out, steps_per_second, stride_length, hr_warm, sample_ovf
  );
  modport slave (
    output run, step_raw, beat_raw, stride_cfg,
    input  valid_out, hr_out, steps_per_second, stride_length, hr_warm, sample_ovf
  );
`else
  modport master (
    input  run, step_raw, beat_raw, stride_cfg,
    output valid_out, hr_out, steps_per_second, stride_length, hr_warm
  );
  modport slave (
    output run, step_raw, beat_raw, stride_cfg,
    input  valid_out, hr_out, steps_per_second, stride_length, hr_warm
  );
`endif
endinterface

// File: rtl/runner_sample_producer.sv
// Turns raw step/heartbeat pulses into one sample per second for the runner accumulator.
// Optional feature macro: RPMS_SAMPLE_OVF_EN adds the sample_ovf saturation flag.
module runner_sample_producer #(
  parameter int CLK_HZ   = 1000,
  parameter int HR_WIN   = 15,
  parameter int DEBOUNCE = 4
) (
  input logic                       clk,
  input logic                       rst,
  runner_sample_producer_if.master  bus
);
  localparam int TW     = $clog2(CLK_HZ);
  localparam int PW     = (HR_WIN > 1) ? $clog2(HR_WIN) : 1;
  localparam int FW     = $clog2(HR_WIN + 1);
  localparam int SW     = $clog2(HR_WIN * 7 + 1);
  localparam int DW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HR_MUL = 60 / HR_WIN;

  logic [2:0]    step_sync, beat_sync;
  logic [DW-1:0] step_db, beat_db;
  logic [TW-1:0] tick;
  logic [2:0]    step_cnt, beat_cnt;
  logic [2:0]    ring [HR_WIN];
  logic [PW-1:0] wr_ptr;
  logic [SW-1:0] sum;
  logic [FW-1:0] fill;

  logic          step_acc, beat_acc, close;
  logic [2:0]    step_next, beat_next;
  logic [SW-1:0] new_sum;
  logic [15:0]   hr_full;
  logic          hr_ovf;
  logic [FW-1:0] fill_next;

  // Edge is seen one cycle after the second sync stage, so raw-to-count is 3 cycles.
  assign step_acc  = step_sync[1] & ~step_sync[2] & (step_db == '0);
  assign beat_acc  = beat_sync[1] & ~beat_sync[2] & (beat_db == '0);
  assign close     = bus.run && (tick == TW'(CLK_HZ - 1));
  assign step_next = (step_cnt == 3'd7) ? 3'd7 : step_cnt + {2'b00, step_acc};
  assign beat_next = (beat_cnt == 3'd7) ? 3'd7 : beat_cnt + {2'b00, beat_acc};
  assign new_sum   = sum - SW'(ring[wr_ptr]) + SW'(beat_next);
  assign hr_full   = 16'(new_sum) * 16'(HR_MUL);
  assign hr_ovf    = (hr_full > 16'd255);
  assign fill_next = (fill == FW'(HR_WIN)) ? fill : fill + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync <= '0;
      beat_sync <= '0;
    end else begin
      step_sync <= {step_sync[1:0], bus.step_raw};
      beat_sync <= {beat_sync[1:0], bus.beat_raw};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_db  <= '0;
      beat_db  <= '0;
      tick     <= '0;
      step_cnt <= '0;
      beat_cnt <= '0;
    end else if (!bus.run) begin
      step_db  <= '0;
      beat_db  <= '0;
      tick     <= '0;
      step_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (step_acc)           step_db <= DW'(DEBOUNCE - 1);
      else if (step_db != '0) step_db <= step_db - 1'b1;
      if (beat_acc)           beat_db <= DW'(DEBOUNCE - 1);
      else if (beat_db != '0) beat_db <= beat_db - 1'b1;
      // An edge accepted on the close cycle is folded into the closing sample via *_next.
      tick     <= close ? '0 : tick + 1'b1;
      step_cnt <= close ? '0 : step_next;
      beat_cnt <= close ? '0 : beat_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HR_WIN; i++) ring[i] <= '0;
      wr_ptr               <= '0;
      sum                  <= '0;
      fill                 <= '0;
      bus.valid_out        <= 1'b0;
      bus.hr_out           <= '0;
      bus.steps_per_second <= '0;
      bus.stride_length    <= '0;
      bus.hr_warm          <= 1'b0;
`ifdef RPMS_SAMPLE_OVF_EN
      bus.sample_ovf       <= 1'b0;
`endif
    end else begin
      bus.valid_out <= close;
      if (close) begin
        ring[wr_ptr]         <= beat_next;
        wr_ptr               <= (wr_ptr == PW'(HR_WIN - 1)) ? '0 : wr_ptr + 1'b1;
        sum                  <= new_sum;
        fill                 <= fill_next;
        bus.hr_out           <= hr_ovf ? 8'hFF : hr_full[7:0];
        bus.steps_per_second <= (step_next > 3'd3) ? 2'd3 : step_next[1:0];
        bus.stride_length    <= bus.stride_cfg;
        bus.hr_warm          <= (fill_next == FW'(HR_WIN));
`ifdef RPMS_SAMPLE_OVF_EN
        bus.sample_ovf       <= (step_next > 3'd3) | (beat_next == 3'd7) | hr_ovf;
`endif
      end
    end
  end
endmodule

// File: tb/tb_runner_sample_producer.sv
// Directed bench for runner_sample_producer: expected samples are queued per window and
// popped by a monitor on each valid_out strobe.
module tb_runner_sample_producer;
  localparam int W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   wpos = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  runner_sample_producer_if bus();

  runner_sample_producer #(.CLK_HZ(1000), .HR_WIN(15), .DEBOUNCE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / reset block; wpos tracks the window position the stimulus expects
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !bus.run)  wpos <= 0;
    else if (wpos == 999) wpos <= 0;
    else                  wpos <= wpos + 1;
  end

  function automatic logic [W-1:0] mk(int hr, int steps, int stride, bit warm, bit ovf);
    bit o;
`ifdef RPMS_SAMPLE_OVF_EN
    o = ovf;
`else
    o = 1'b0;
`endif
    return {o, warm, 8'(stride), 2'(steps), 8'(hr)};
  endfunction

  function automatic logic [W-1:0] act_sample();
    logic o;
`ifdef RPMS_SAMPLE_OVF_EN
    o = bus.sample_ovf;
`else
    o = 1'b0;
`endif
    return {o, bus.hr_warm, bus.stride_length, bus.steps_per_second, bus.hr_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.valid_out === 1'b1) begin
      check("no_back_to_back", 32'(prev_valid), 32'(0));
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got 0x%0h, want no strobe (cycle %0d)", act_sample(), cyc);
      end else begin
        e = exp_q.pop_front();
        check("sample", 32'(act_sample()), 32'(e));
      end
    end
    prev_valid = bus.valid_out;
  end

  // driver tasks
  task automatic goto_tick(input int t);
    @(negedge clk);
    while (wpos != t) @(negedge clk);
  endtask

  task automatic end_window();
    while (wpos != 999) @(negedge clk);
  endtask

  task automatic step_at(input int t);
    goto_tick(t);
    bus.step_raw = 1'b1;
    @(negedge clk);
    bus.step_raw = 1'b0;
  endtask

  task automatic beat_at(input int t);
    goto_tick(t);
    bus.beat_raw = 1'b1;
    @(negedge clk);
    bus.beat_raw = 1'b0;
  endtask

  // called at the close-cycle negedge: no strobe yet, strobe on the following cycle
  task automatic check_strobe_edge(input string name);
    check({name, "_early"}, 32'(bus.valid_out), 32'(0));
    @(negedge clk);
    check(name, 32'(bus.valid_out), 32'(1));
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    int nv;
    bus.run = 1'b1;
    bus.step_raw = 1'b0;
    bus.beat_raw = 1'b0;
    bus.stride_cfg = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", 32'({bus.valid_out, act_sample()}), 32'(0));

    // empty first window, 1000-cycle latency from release
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    end_window();
    check_strobe_edge("first_strobe_latency");

    bus.stride_cfg = 8'd75;
    exp_q.push_back(mk(0, 2, 75, 0, 0));
    step_at(100);
    step_at(300);
    end_window();

    exp_q.push_back(mk(0, 3, 75, 0, 1));
    for (int i = 1; i <= 5; i++) step_at(i * 100);
    end_window();

    // bounce: sampled 1,0,1,0 plus a sub-cycle glitch -> one count
    exp_q.push_back(mk(0, 1, 75, 0, 0));
    goto_tick(100);
    bus.step_raw = 1'b1; @(negedge clk);
    bus.step_raw = 1'b0; @(negedge clk);
    bus.step_raw = 1'b1; @(negedge clk);
    bus.step_raw = 1'b0; #1 bus.step_raw = 1'b1; #1 bus.step_raw = 1'b0;
    end_window();

    // edge accepted on the close cycle counts in the closing window
    exp_q.push_back(mk(0, 1, 75, 0, 0));
    step_at(997);
    end_window();

    // edge one cycle later lands in the next window
    exp_q.push_back(mk(0, 0, 75, 0, 0));
    step_at(998);
    end_window();
    exp_q.push_back(mk(0, 1, 75, 0, 0));
    goto_tick(500);
    end_window();

    // mid-window reset
    goto_tick(600);
    rst = 1'b1;
    #1;
    check("mid_reset_clear", 32'({bus.valid_out, act_sample()}), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // heart rate: two beats per window, 500 cycles apart
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(mk((8 * k > 120) ? 120 : 8 * k, 0, 75, k >= 15, 0));
      beat_at(100);
      beat_at(600);
      end_window();
      if (k == 1) check_strobe_edge("post_reset_latency");
    end

    // run gating: partial window discarded, pulses while run=0 ignored
    beat_at(100);
    step_at(200);
    goto_tick(400);
    bus.run = 1'b0;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      bus.step_raw = (i == 50);
      bus.beat_raw = (i == 60);
      @(negedge clk);
      if (bus.valid_out === 1'b1) nv++;
    end
    bus.step_raw = 1'b0;
    bus.beat_raw = 1'b0;
    check("run_low_no_strobe", 32'(nv), 32'(0));
    check("run_low_hold", 32'(act_sample()), 32'(mk(120, 0, 75, 1, 0)));
    bus.run = 1'b1;
    // ring of 2s loses its oldest entry and gains a 1: 29 * 4
    exp_q.push_back(mk(116, 1, 75, 1, 0));
    beat_at(100);
    step_at(300);
    end_window();
    check_strobe_edge("run_rise_latency");

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    report();
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    report();
    $fatal(1, "watchdog expired");
  end
endmodule
